// File: rtl/bs_arb_pkg.sv
// bs_arb_pkg: shared state encoding, ID width and round-robin helper for the bus arbiter.
package bs_arb_pkg;

    localparam int ID_W = 8;

    typedef enum logic [1:0] {IDLE, POP, PUSH, DROP} arb_state_e;

    // Index of the first set bit at or after ptr, wrapping; unused upper request bits must be 0.
    function automatic logic [ID_W-1:0] rr_next(input logic [255:0] req, input logic [ID_W-1:0] ptr);
        logic [ID_W-1:0] idx;
        rr_next = ptr;
        for (int i = 255; i >= 0; i--) begin
            idx = ptr + ID_W'(i);
            if (req[idx]) rr_next = idx;
        end
    endfunction

endpackage

// File: rtl/bs_arb_lane.sv
// bs_arb_lane: one bus lane - round-robin grant, pop, then push/broadcast or drop the packet.
module bs_arb_lane
    import bs_arb_pkg::*;
#(
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = 8'hFF,
    parameter int              CNT_W     = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [drvrs-1:0]                 pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]    D_pop,
    output logic [drvrs-1:0]                 pop,
    output logic [drvrs-1:0]                 push,
    output logic [drvrs-1:0][pckg_sz-1:0]    D_push,
    output logic [CNT_W-1:0]                 drop_cnt,
    output logic                             busy
);

    localparam int GW = $clog2(drvrs);

    arb_state_e         state_q;
    logic [GW-1:0]      grant_q, ptr_q, pick, ptr_nxt;
    logic [pckg_sz-1:0] pkt_q, head;
    logic [ID_W-1:0]    dest;
    logic [drvrs-1:0]   pop_q, push_q, tgt;
    logic [CNT_W-1:0]   drop_q;
    logic               busy_q;

    assign pick    = GW'(rr_next(256'(pndng), ID_W'(ptr_q)));
    assign head    = D_pop[grant_q];
    assign dest    = head[pckg_sz-1 -: ID_W];
    assign ptr_nxt = (grant_q == GW'(drvrs-1)) ? '0 : grant_q + 1'b1;

    always_comb
        tgt = (dest == broadcast) ? ~(drvrs'(1) << grant_q) :
              (dest < ID_W'(drvrs) && dest != ID_W'(grant_q)) ? drvrs'(1) << dest : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            pkt_q   <= '0;
            pop_q   <= '0;
            push_q  <= '0;
            drop_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (|pndng) begin
                    grant_q <= pick;
                    pop_q   <= drvrs'(1) << pick;
                    busy_q  <= 1'b1;
                    state_q <= POP;
                end
                POP: begin
                    pop_q   <= '0;
                    pkt_q   <= head;
                    push_q  <= tgt;
                    state_q <= |tgt ? PUSH : DROP;
                end
                PUSH: begin
                    push_q  <= '0;
                    ptr_q   <= ptr_nxt;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                DROP: begin
                    drop_q  <= &drop_q ? drop_q : drop_q + 1'b1;
                    ptr_q   <= ptr_nxt;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data lines carry the packet only on targets during the push cycle.
    for (genvar k = 0; k < drvrs; k++) begin : g_dp
        assign D_push[k] = push_q[k] ? pkt_q : '0;
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign drop_cnt = drop_q;
    assign busy     = busy_q;

endmodule

// File: rtl/bs_rr_arbtr_bcst.sv
// bs_rr_arbtr_bcst: multi-bus round-robin arbiter/router, one independent lane per bus.
module bs_rr_arbtr_bcst
    import bs_arb_pkg::*;
#(
    parameter int              bits      = 1,
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter logic [ID_W-1:0] broadcast = 8'hFF,
    parameter int              CNT_W     = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [bits-1:0][drvrs-1:0]                pndng,
    input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [bits-1:0][drvrs-1:0]                pop,
    output logic [bits-1:0][drvrs-1:0]                push,
    output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_push,
    output logic [bits-1:0][CNT_W-1:0]                drop_cnt,
    output logic [bits-1:0]                           busy
);

    for (genvar b = 0; b < bits; b++) begin : g_lane
        bs_arb_lane #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast),
            .CNT_W     (CNT_W)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .pndng    (pndng[b]),
            .D_pop    (D_pop[b]),
            .pop      (pop[b]),
            .push     (push[b]),
            .D_push   (D_push[b]),
            .drop_cnt (drop_cnt[b]),
            .busy     (busy[b])
        );
    end

endmodule

// File: tb/tb_bs_rr_arbtr_bcst.sv
// tb_bs_rr_arbtr_bcst: directed checks of grant order, routing, drops and reset on a 2-lane, 4-device arbiter.
module tb_bs_rr_arbtr_bcst;

    localparam int B = 2, N = 4, W = 16, C = 16;

    logic                       clk = 1'b0;
    logic                       reset = 1'b0;
    logic [B-1:0][N-1:0]        pndng = '0;
    logic [B-1:0][N-1:0][W-1:0] D_pop = '0;
    logic [B-1:0][N-1:0]        pop, push;
    logic [B-1:0][N-1:0][W-1:0] D_push;
    logic [B-1:0][C-1:0]        drop_cnt;
    logic [B-1:0]               busy;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    bs_rr_arbtr_bcst #(.bits(B), .drvrs(N), .pckg_sz(W), .broadcast(8'hFF), .CNT_W(C)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
        .D_push(D_push), .drop_cnt(drop_cnt), .busy(busy)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] dp(input logic [N-1:0] m, input logic [W-1:0] d);
        logic [N-1:0][W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) if (m[k]) r[k] = d;
        return 128'(r);
    endfunction

    // One packet through a lane; called at a negedge with the lane idle.
    task automatic xfer(input string tag, input int l, input int s, input logic [W-1:0] d,
                        input logic [N-1:0] m, input int drops);
        pndng[l][s] = 1'b1;
        D_pop[l][s] = d;
        @(negedge clk);
        chk({tag, "_pop"}, pop[l], 128'(1 << s));
        chk({tag, "_busy"}, busy[l], 1);
        pndng[l][s] = 1'b0;
        @(negedge clk);
        chk({tag, "_push"}, push[l], m);
        chk({tag, "_dpush"}, D_push[l], dp(m, d));
        chk({tag, "_nopop"}, pop[l], 0);
        @(negedge clk);
        chk({tag, "_idle"}, {busy[l], push[l]}, 0);
        chk({tag, "_drops"}, drop_cnt[l], drops);
    endtask

    initial begin
        logic [N-1:0][W-1:0] rr_d;
        int rr_dst [N];
        rr_d   = {16'h02DD, 16'h03CC, 16'h00BB, 16'h01AA};
        rr_dst = '{1, 0, 3, 2};

        @(negedge clk);
        chk("rst_out", {pop, push, D_push}, 0);
        chk("rst_cnt", {drop_cnt, busy}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Round-robin: all four pending together
        pndng[0] = 4'hF;
        D_pop[0] = rr_d;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_pop", i), pop[0], 128'(1 << i));
            pndng[0][i] = 1'b0;
            @(negedge clk);
            chk($sformatf("rr%0d_push", i), push[0], 128'(1 << rr_dst[i]));
            chk($sformatf("rr%0d_dpush", i), D_push[0], dp(N'(1 << rr_dst[i]), rr_d[i]));
            @(negedge clk);
            chk($sformatf("rr%0d_gap", i), {pop[0], push[0]}, 0);
        end

        xfer("uni", 0, 0, 16'h02AA, 4'b0100, 0);
        xfer("bc", 0, 1, 16'hFF55, 4'b1101, 0);
        chk("bc_lane1", {push[1], pop[1], busy[1]}, 0);
        xfer("drop_bad", 0, 2, 16'h07CC, 4'b0000, 1);
        xfer("drop_self", 0, 2, 16'h02CC, 4'b0000, 2);

        // Reset mid-packet: rr_ptr is now 3, so dev3 wins before reset
        pndng[0] = 4'b1010;
        D_pop[0][1] = 16'h0311;
        D_pop[0][3] = 16'h0011;
        @(negedge clk);
        chk("rm_pop", pop[0], 4'b1000);
        @(negedge clk);
        chk("rm_push", push[0], 4'b0001);
        reset = 1'b0;
        #1;
        chk("rm_async", {pop, push, D_push}, 0);
        chk("rm_state", {drop_cnt, busy}, 0);
        @(negedge clk);
        reset = 1'b1;
        chk("rm_nodeliver", push, 0);
        @(negedge clk);
        chk("rm_lowest", pop[0], 4'b0010);
        pndng[0] = '0;
        @(negedge clk);
        chk("rm_push2", push[0], 4'b1000);
        chk("rm_dpush2", D_push[0], dp(4'b1000, 16'h0311));
        @(negedge clk);

        // Lane independence
        pndng[0][0] = 1'b1;
        D_pop[0][0] = 16'h0311;
        pndng[1][3] = 1'b1;
        D_pop[1][3] = 16'h0022;
        @(negedge clk);
        chk("li_pop", pop, {4'b1000, 4'b0001});
        pndng = '0;
        @(negedge clk);
        chk("li_push", push, {4'b0001, 4'b1000});
        chk("li_dp0", D_push[0], dp(4'b1000, 16'h0311));
        chk("li_dp1", D_push[1], dp(4'b0001, 16'h0022));
        @(negedge clk);
        chk("li_idle", {busy, push, pop}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
